// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC iteration controller.
// Holds the controller state encoding, status bit positions, mode/system
// encodings and the turn constants used for quadrant pre-correction.
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } ctrlState_t;

  localparam int STATUS_W   = 6;
  localparam int ST_INP_ERR = 0;
  localparam int ST_OV_ERR  = 1;
  localparam int ST_X_OV    = 2;
  localparam int ST_Y_OV    = 3;
  localparam int ST_Z_OV    = 4;
  localparam int ST_ABORTED = 5;

  localparam logic CIRCULAR   = 1'b1;
  localparam logic HYPERBOLIC = 1'b0;
  localparam logic ROTATION   = 1'b1;
  localparam logic VECTOR     = 1'b0;

  // First hyperbolic shift that must be executed twice; later ones follow 3k+1.
  localparam int REPEAT_INIT = 4;

  // Angles are binary: 2^width is one full turn. Valid for width <= 64.
  function automatic logic [63:0] quarterTurn(input int width);
    return 64'd1 << (width - 2);
  endfunction

  function automatic logic [63:0] halfTurn(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// Single combinational CORDIC micro-rotation.
// Ports:
//   x, y, z    current vector and residual angle (signed, WIDTH bits)
//   angle      arctan/artanh of 2^-shift from the external LUT
//   shift      shift amount for this micro-rotation
//   mode       rotation / vectoring (selects the direction rule)
//   system     circular / hyperbolic (selects the sign of the x update)
//   xNext..    updated vector and angle, WIDTH-bit wrapping
//   xOv..      signed add/sub overflow of each update
module cordic_iter_stage
  import cordic_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic signed [WIDTH-1:0]  x,
  input  logic signed [WIDTH-1:0]  y,
  input  logic signed [WIDTH-1:0]  z,
  input  logic signed [WIDTH-1:0]  angle,
  input  logic        [ITER_W-1:0] shift,
  input  logic                     mode,
  input  logic                     system,
  output logic signed [WIDTH-1:0]  xNext,
  output logic signed [WIDTH-1:0]  yNext,
  output logic signed [WIDTH-1:0]  zNext,
  output logic                     xOv,
  output logic                     yOv,
  output logic                     zOv
);

  function automatic logic addSubOv(input logic aMsb, input logic bMsb,
                                    input logic rMsb, input logic sub);
    // a+b overflows when operands agree in sign and the result does not;
    // a-b overflows when operands differ in sign and the result flips from a.
    return sub ? ((aMsb != bMsb) && (rMsb != aMsb))
               : ((aMsb == bMsb) && (rMsb != aMsb));
  endfunction

  logic                    dPos;
  logic                    subX;
  logic                    subY;
  logic                    subZ;
  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;

  always_comb begin
    dPos = (mode == ROTATION) ? ~z[WIDTH-1] : y[WIDTH-1];
    xs   = x >>> shift;
    ys   = y >>> shift;
    // x' = x - m*d*ys : circular subtracts for d=+1, hyperbolic adds.
    subX = (system == CIRCULAR) ? dPos : ~dPos;
    subY = ~dPos;
    subZ = dPos;

    xNext = subX ? (x - ys) : (x + ys);
    yNext = subY ? (y - xs) : (y + xs);
    zNext = subZ ? (z - angle) : (z + angle);

    xOv = addSubOv(x[WIDTH-1], ys[WIDTH-1], xNext[WIDTH-1], subX);
    yOv = addSubOv(y[WIDTH-1], xs[WIDTH-1], yNext[WIDTH-1], subY);
    zOv = addSubOv(z[WIDTH-1], angle[WIDTH-1], zNext[WIDTH-1], subZ);
  end

endmodule

// File: rtl/cordic_iter_controller.sv
// Handshake-driven CORDIC sequencer: accepts one job, applies quadrant
// pre-correction, runs one micro-rotation per cycle using an external
// arctan/artanh LUT, and returns results with backpressure.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_valid/in_ready    job channel; in_x/in_y/in_z, in_mode, in_system,
//                        in_iters, in_ov_stop_en, in_z_ov_stop_en
//   abort                terminate a running job (only honoured in ITER)
//   lut_offset/system    LUT address; lut_angle returns same cycle
//   out_valid/out_ready  result channel; out_x/out_y/out_z, out_status,
//                        out_iters_done, out_ov_iter
//
// state | meaning
// IDLE  | ready for a job, in_ready high
// PRE   | quadrant correction / hyperbolic input check, shift init
// ITER  | one micro-rotation per cycle until count, overflow stop or abort
// DONE  | result held until out_ready
module cordic_iter_controller
  import cordic_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ITER_W        = 6,
  parameter bit HYP_REPEAT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_y,
  input  logic [WIDTH-1:0]    in_z,
  input  logic                in_mode,
  input  logic                in_system,
  input  logic [ITER_W-1:0]   in_iters,
  input  logic                in_ov_stop_en,
  input  logic                in_z_ov_stop_en,
  input  logic                abort,
  output logic [ITER_W-1:0]   lut_offset,
  output logic                lut_system,
  input  logic [WIDTH-1:0]    lut_angle,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_x,
  output logic [WIDTH-1:0]    out_y,
  output logic [WIDTH-1:0]    out_z,
  output logic [STATUS_W-1:0] out_status,
  output logic [ITER_W-1:0]   out_iters_done,
  output logic [ITER_W-1:0]   out_ov_iter
);

  // Repeat target grows as 3k+1; two spare bits keep it from wrapping
  // back into the reachable shift range.
  localparam int                TGT_W     = ITER_W + 2;
  localparam logic [WIDTH-1:0]  HALF_TURN = WIDTH'(halfTurn(WIDTH));
  localparam logic [ITER_W-1:0] SHIFT_MAX = ITER_W'(WIDTH - 1);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [TGT_W-1:0]  TGT_ONE   = TGT_W'(1);
  localparam logic [TGT_W-1:0]  TGT_INIT  = TGT_W'(REPEAT_INIT);

  ctrlState_t state, stateNext;

  logic signed [WIDTH-1:0] xReg, yReg, zReg;
  logic                    modeReg, systemReg, ovStopEnReg, zOvStopEnReg;
  logic [ITER_W-1:0]       itersReg, shiftReg, iterDone, ovIter;
  logic [TGT_W-1:0]        repeatTarget;
  logic [STATUS_W-1:0]     status;

  logic signed [WIDTH-1:0] xNext, yNext, zNext;
  logic                    xOv, yOv, zOv;

  logic [WIDTH-1:0]        absY;
  logic                    preErr, preCorr, preDone;
  logic [ITER_W-1:0]       iterDoneInc;
  logic                    itersHit, iterExit, hypRepeat;
  logic [STATUS_W-1:0]     statusIter;

  cordic_iter_stage #(
    .WIDTH (WIDTH),
    .ITER_W(ITER_W)
  ) uStage (
    .x     (xReg),
    .y     (yReg),
    .z     (zReg),
    .angle (lut_angle),
    .shift (shiftReg),
    .mode  (modeReg),
    .system(systemReg),
    .xNext (xNext),
    .yNext (yNext),
    .zNext (zNext),
    .xOv   (xOv),
    .yOv   (yOv),
    .zOv   (zOv)
  );

  always_comb begin
    absY    = yReg[WIDTH-1] ? -yReg : yReg;
    preErr  = (systemReg == HYPERBOLIC) &&
              (xReg[WIDTH-1] || (absY >= $unsigned(xReg)));
    // |z| > 90 deg shows up as the top two angle bits disagreeing.
    preCorr = (systemReg == CIRCULAR) &&
              ((modeReg == ROTATION) ? (zReg[WIDTH-1] != zReg[WIDTH-2])
                                     : xReg[WIDTH-1]);
    preDone = preErr || (itersReg == '0);

    iterDoneInc = iterDone + ITER_ONE;
    itersHit    = (iterDoneInc == itersReg);

    statusIter              = status;
    statusIter[ST_X_OV]     = status[ST_X_OV] | xOv;
    statusIter[ST_Y_OV]     = status[ST_Y_OV] | yOv;
    statusIter[ST_Z_OV]     = status[ST_Z_OV] | zOv;
    statusIter[ST_OV_ERR]   = statusIter[ST_X_OV] | statusIter[ST_Y_OV] |
                              statusIter[ST_Z_OV];
    statusIter[ST_ABORTED]  = abort & ~itersHit;

    iterExit = itersHit || abort ||
               (ovStopEnReg && (statusIter[ST_X_OV] || statusIter[ST_Y_OV])) ||
               (ovStopEnReg && zOvStopEnReg && statusIter[ST_Z_OV]);

    hypRepeat = HYP_REPEAT_EN && (systemReg == HYPERBOLIC) &&
                ({2'b00, shiftReg} == repeatTarget);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = PRE;
      PRE:     stateNext = preDone ? DONE : ITER;
      ITER:    if (iterExit) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xReg         <= '0;
      yReg         <= '0;
      zReg         <= '0;
      modeReg      <= 1'b0;
      systemReg    <= 1'b0;
      ovStopEnReg  <= 1'b0;
      zOvStopEnReg <= 1'b0;
      itersReg     <= '0;
      shiftReg     <= '0;
      iterDone     <= '0;
      ovIter       <= '0;
      repeatTarget <= '0;
      status       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xReg         <= in_x;
            yReg         <= in_y;
            zReg         <= in_z;
            modeReg      <= in_mode;
            systemReg    <= in_system;
            itersReg     <= in_iters;
            ovStopEnReg  <= in_ov_stop_en;
            zOvStopEnReg <= in_z_ov_stop_en;
            iterDone     <= '0;
            ovIter       <= '0;
            status       <= '0;
          end
        end
        PRE: begin
          if (preCorr) begin
            xReg <= -xReg;
            yReg <= -yReg;
            zReg <= zReg + HALF_TURN;
          end
          if (preErr) status[ST_INP_ERR] <= 1'b1;
          shiftReg     <= (systemReg == CIRCULAR) ? '0 : ITER_ONE;
          repeatTarget <= TGT_INIT;
        end
        ITER: begin
          xReg     <= xNext;
          yReg     <= yNext;
          zReg     <= zNext;
          iterDone <= iterDoneInc;
          status   <= statusIter;
          if ((xOv || yOv || zOv) && !status[ST_OV_ERR]) ovIter <= iterDone;
          if (hypRepeat) begin
            repeatTarget <= repeatTarget + (repeatTarget << 1) + TGT_ONE;
          end else if (shiftReg != SHIFT_MAX) begin
            shiftReg <= shiftReg + ITER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst so every output reads 0 while held in reset.
  assign in_ready       = rst && (state == IDLE);
  assign out_valid      = (state == DONE);
  assign out_x          = xReg;
  assign out_y          = yReg;
  assign out_z          = zReg;
  assign out_status     = status;
  assign out_iters_done = iterDone;
  assign out_ov_iter    = ovIter;
  assign lut_offset     = shiftReg;
  assign lut_system     = systemReg;

endmodule

// File: tb/tb_cordic_iter_controller.sv
// Directed bench for cordic_iter_controller with a real-valued LUT model.
module tb_cordic_iter_controller;
  import cordic_ctrl_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ITER_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [WIDTH-1:0]  in_x, in_y, in_z;
  logic              in_mode, in_system;
  logic [ITER_W-1:0] in_iters;
  logic              in_ov_stop_en, in_z_ov_stop_en;
  logic              abort;
  logic [ITER_W-1:0] lut_offset;
  logic              lut_system;
  logic [WIDTH-1:0]  lut_angle;
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  out_x, out_y, out_z;
  logic [5:0]        out_status;
  logic [ITER_W-1:0] out_iters_done, out_ov_iter;

  int nChecks = 0;
  int nErrors = 0;
  int cyc;
  int offLog [256];
  int expSeq [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
  logic [31:0] atanTab [64];
  logic [31:0] atanhTab [64];

  always #5 clk = ~clk;

  assign lut_angle = lut_system ? atanTab[lut_offset] : atanhTab[lut_offset];

  cordic_iter_controller #(
    .WIDTH        (WIDTH),
    .ITER_W       (ITER_W),
    .HYP_REPEAT_EN(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .in_y           (in_y),
    .in_z           (in_z),
    .in_mode        (in_mode),
    .in_system      (in_system),
    .in_iters       (in_iters),
    .in_ov_stop_en  (in_ov_stop_en),
    .in_z_ov_stop_en(in_z_ov_stop_en),
    .abort          (abort),
    .lut_offset     (lut_offset),
    .lut_system     (lut_system),
    .lut_angle      (lut_angle),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_x          (out_x),
    .out_y          (out_y),
    .out_z          (out_z),
    .out_status     (out_status),
    .out_iters_done (out_iters_done),
    .out_ov_iter    (out_ov_iter)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkNear(input string tag, input logic signed [31:0] obs,
                           input longint exp, input longint tol);
    longint diff;
    diff = longint'(obs) - exp;
    if (diff < 0) diff = -diff;
    nChecks++;
    assert (diff <= tol) else begin
      nErrors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic startJob(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic mode, input logic sys, input logic [5:0] iters,
                          input logic ovEn, input logic zovEn);
    @(negedge clk);
    in_x = x; in_y = y; in_z = z;
    in_mode = mode; in_system = sys; in_iters = iters;
    in_ov_stop_en = ovEn; in_z_ov_stop_en = zovEn;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // cycle 0 is the accepting cycle; returns the cycle in which out_valid is seen
  task automatic waitDone(input int abortAt, output int latency);
    int c;
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (c < 256) offLog[c] = int'(lut_offset);
      abort = (c == abortAt);
      if (out_valid) break;
    end
    abort = 1'b0;
    check("done_timeout", out_valid, 1);
    latency = c;
  endtask

  task automatic finishJob();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    real t, pi;
    pi = 3.14159265358979323846;
    for (int s = 0; s < 64; s++) begin
      t = 2.0 ** (-s);
      atanTab[s] = 32'($rtoi($atan(t) / (2.0 * pi) * 4294967296.0 + 0.5));
      if (s == 0) atanhTab[s] = '0;
      else atanhTab[s] = 32'($rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) / (2.0 * pi) * 4294967296.0 + 0.5));
    end

    rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; in_mode = 1'b0; in_system = 1'b0;
    in_iters = '0; in_ov_stop_en = 1'b0; in_z_ov_stop_en = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_status", out_status, 0);

    // circular rotation by 45 degrees
    startJob(32'h4000_0000, 32'h0, 32'h2000_0000, ROTATION, CIRCULAR, 6'd31, 1'b0, 1'b0);
    waitDone(0, cyc);
    check("lat_45", cyc, 33);
    checkNear("x_45", out_x, 64'sh4A86_0000, 65536);
    checkNear("y_45", out_y, 64'sh4A86_0000, 65536);
    checkNear("z_45", out_z, 0, 15);
    check("status_45", out_status, 6'b000000);
    check("iters_45", out_iters_done, 31);
    check("busy_in_ready", in_ready, 0);
    finishJob();

    // circular rotation by 135 degrees: pre-correction path
    startJob(32'h4000_0000, 32'h0, 32'h6000_0000, ROTATION, CIRCULAR, 6'd31, 1'b0, 1'b0);
    waitDone(0, cyc);
    check("lat_135", cyc, 33);
    checkNear("x_135", out_x, -64'sh4A86_0000, 65536);
    checkNear("y_135", out_y, 64'sh4A86_0000, 65536);
    check("status_135", out_status, 6'b000000);
    finishJob();

    // hyperbolic vectoring with |y| >= x: input error, no iterations
    startJob(32'h1000_0000, 32'h2000_0000, 32'h0, VECTOR, HYPERBOLIC, 6'd16, 1'b0, 1'b0);
    waitDone(0, cyc);
    check("lat_inp_err", cyc, 2);
    check("status_inp_err", out_status, 6'b000001);
    check("iters_inp_err", out_iters_done, 0);
    finishJob();

    // hyperbolic 16 iterations: repeat at shifts 4 and 13
    startJob(32'h4000_0000, 32'h0, 32'h0, ROTATION, HYPERBOLIC, 6'd16, 1'b0, 1'b0);
    waitDone(0, cyc);
    check("lat_hyp", cyc, 18);
    check("iters_hyp", out_iters_done, 16);
    check("status_hyp", out_status, 6'b000000);
    for (int k = 0; k < 16; k++) check($sformatf("hyp_shift_%0d", k), offLog[k + 2], expSeq[k]);
    finishJob();

    // overflow on first iteration, then hold result under backpressure
    startJob(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, ROTATION, CIRCULAR, 6'd31, 1'b1, 1'b0);
    waitDone(0, cyc);
    check("lat_ov0", cyc, 3);
    check("status_ov0", out_status, 6'b001010);
    check("iters_ov0", out_iters_done, 1);
    check("ov_iter_ov0", out_ov_iter, 0);
    check("x_ov0", out_x, 32'h0000_0000);
    check("y_ov0", out_y, 32'hFFFE_0000);
    check("z_ov0", out_z, 32'hE000_0000);
    repeat (10) @(negedge clk);
    check("stall_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    check("stall_y", out_y, 32'hFFFE_0000);
    check("stall_status", out_status, 6'b001010);
    finishJob();

    // overflow on second iteration
    startJob(32'h7000_0000, 32'h0, 32'h2000_0000, ROTATION, CIRCULAR, 6'd31, 1'b1, 1'b0);
    waitDone(0, cyc);
    check("lat_ov1", cyc, 4);
    check("status_ov1", out_status, 6'b001010);
    check("iters_ov1", out_iters_done, 2);
    check("ov_iter_ov1", out_ov_iter, 1);
    check("x_ov1", out_x, 32'h3800_0000);
    check("y_ov1", out_y, 32'hA800_0000);
    finishJob();

    // abort during the fifth ITER cycle
    startJob(32'h4000_0000, 32'h0, 32'h2000_0000, ROTATION, CIRCULAR, 6'd31, 1'b0, 1'b0);
    waitDone(6, cyc);
    check("lat_abort", cyc, 7);
    check("status_abort", out_status, 6'b100000);
    check("iters_abort", out_iters_done, 5);
    finishJob();

    // reset pulse in the middle of ITER
    startJob(32'h4000_0000, 32'h0, 32'h2000_0000, ROTATION, CIRCULAR, 6'd31, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_x", out_x, 0);
    check("mid_rst_z", out_z, 0);
    check("mid_rst_iters", out_iters_done, 0);
    check("mid_rst_lut_offset", lut_offset, 0);
    check("mid_rst_lut_system", lut_system, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    @(negedge clk);
    check("mid_rst_no_output", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/cordic_iter_controller.md
Name: cordic_iter_controller

Overview:
- Parametrised, handshake-driven successor to the single-width CORDIC sequencer.
- Accepts one job (x, y, z, mode, system, iteration count) over a valid/ready input channel.
- Performs quadrant pre-correction, then runs one CORDIC micro-rotation per cycle through an internal stage, fed by an external arctan/artanh LUT.
- Returns results and status over a valid/ready output channel with backpressure.
- New capabilities: generic width, automatic hyperbolic repeat iterations (4, 13, 40, ...), abort, and backpressured output.

Parameters:
- WIDTH, 32, datapath width. x/y are signed with 2 integer bits (Q2.(WIDTH-2)). z is a signed binary angle: 2^WIDTH equals one full turn, so 90° = 2^(WIDTH-2).
- ITER_W, 6, width of the iteration count and shift fields.
- HYP_REPEAT_EN, 1, enables repeat iterations in hyperbolic mode.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  controller can accept a job (IDLE)
- in_x, in_y, in_z  in  WIDTH each  initial vector and angle
- in_mode  in  1  1 = rotation, 0 = vectoring
- in_system  in  1  1 = circular, 0 = hyperbolic
- in_iters  in  ITER_W  micro-rotations to perform
- in_ov_stop_en  in  1  stop on x/y overflow
- in_z_ov_stop_en  in  1  also stop on z overflow (only effective with in_ov_stop_en)
- abort  in  1  terminate the running job
- lut_offset  out  ITER_W  current shift amount
- lut_system  out  1  latched system
- lut_angle  in  WIDTH  angle for lut_offset/lut_system, combinational same-cycle
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_x, out_y, out_z  out  WIDTH each  results
- out_status  out  6  bit 0 inp_err, bit 1 ov_err, bit 2 x_ov, bit 3 y_ov, bit 4 z_ov, bit 5 aborted
- out_iters_done  out  ITER_W  micro-rotations executed
- out_ov_iter  out  ITER_W  index of first overflowing iteration (0 if none)

Behaviour:
- Reset: rst low asynchronously forces state IDLE and clears all registers. While rst is low, all outputs are 0, including in_ready. After release, in_ready = 1.
- States: IDLE, PRE, ITER, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid the job is latched (all in_* fields) → PRE.
  - Status, iteration counter and ov_iter are cleared at this point.
- PRE (1 cycle):
  - Circular rotation: if z[W-1] != z[W-2] (|z| > 90°), then x ← -x, y ← -y, z ← z + 2^(W-1).
  - Circular vectoring: if x < 0, apply the same correction.
  - Hyperbolic: if x < 0 or |y| ≥ x, set inp_err → DONE with no iterations.
  - Shift init: 0 for circular, 1 for hyperbolic. Repeat target init: 4.
  - If in_iters == 0 → DONE; otherwise → ITER.
- ITER (one micro-rotation per cycle):
  - Direction d: rotation mode uses d = +1 if z ≥ 0, else -1. Vectoring mode uses d = +1 if y < 0, else -1.
  - Update: x' = x - m·d·(y>>>s), y' = y + d·(x>>>s), z' = z - d·lut_angle, with m = +1 circular, -1 hyperbolic. All arithmetic is WIDTH-bit wrapping.
  - Overflow: x_ov, y_ov and z_ov are signed-add overflows of the current cycle and are sticky. ov_err = OR of the three. out_ov_iter captures the iters_done value on the first overflow.
  - Shift advance: s increments, saturating at WIDTH-1. In hyperbolic mode with HYP_REPEAT_EN, when s equals the repeat target and this is its first use, s is held for one more cycle and the target becomes 3·target + 1.
  - iters_done increments every ITER cycle.
- Exit from ITER → DONE when any of the following holds, evaluated on post-update values in the same cycle:
  - iters_done reaches in_iters;
  - ov_stop_en and (x_ov or y_ov);
  - ov_stop_en and z_ov_stop_en and z_ov;
  - abort.
  - aborted is set only if the exit occurred by abort while the count was not yet reached.
  - abort is ignored outside ITER.
- DONE:
  - out_valid = 1; outputs are stable while out_ready = 0.
  - On out_valid & out_ready → IDLE. out_valid drops in the next cycle.
- Latency: a job accepted at cycle 0 yields out_valid at cycle N+2, where N = iterations executed.
- Reset mid-job: the job is discarded with no output.
- Repeat target exceeding WIDTH-1 has no effect.

Decomposition:
- Package cordic_ctrl_pkg:
  - state enum;
  - status bit indices;
  - CIRCULAR/HYPERBOLIC and ROTATION/VECTOR constants;
  - quarter/half-turn constants as functions of WIDTH.
- Sub-module cordic_iter_stage: combinational single micro-rotation with overflow flags, parametrised by WIDTH/ITER_W.

Test Plan:
- Circular rotation, 45°: x=0x4000_0000, y=0, z=0x2000_0000, iters=31 → out_x ≈ out_y ≈ 0x4A86_0000 ±2^16, |out_z| < 2^4; out_valid asserted 33 cycles after acceptance.
- Circular rotation, 135°: z=0x6000_0000 → pre-correction applied; out_x ≈ -0x4A86_0000, out_y ≈ +0x4A86_0000.
- Hyperbolic vectoring, bad input: x=0x1000_0000, y=0x2000_0000 → status=0b000001, out_iters_done=0, out_valid asserted 2 cycles after acceptance.
- Hyperbolic, iters=16: lut_offset sequence 1,2,3,4,4,5,…,13,13,14 → out_iters_done=16.
- Overflow stop: x=y=0x7FFF_0000, circular, ov_stop_en=1 → stops after the iteration with x_ov/y_ov; ov_err=1; out_ov_iter equals that index.
- Control events:
  - abort at ITER cycle 5 → aborted=1, out_iters_done=5;
  - out_ready held low for 10 cycles → outputs stable, in_ready=0;
  - rst pulse low mid-ITER → immediate IDLE, all outputs 0.
